// File: rtl/imem_loader.sv
// imem_loader: boot loader that writes a framed, checksummed big-endian word stream into instruction memory and releases cpu_hold on success
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [15:0]       word_count
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR} state_t;
  state_t state;
  logic [15:0] len;
  logic [7:0] acc;
  logic [1:0] bidx;
  logic [23:0] sh;
  logic hs;
  logic [15:0] n;
  logic [ADDR_W-1:0] waddr;
  assign hs = byte_valid & byte_ready;
  assign n = {len[15:8], byte_in};
  assign waddr = BASE_ADDR + ADDR_W'({word_count, 2'b00});
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      byte_ready <= 1'b0;
      imem_we <= 1'b0;
      imem_addr <= BASE_ADDR;
      imem_wdata <= '0;
      cpu_hold <= 1'b1;
      done <= 1'b0;
      error <= 1'b0;
      err_code <= 2'b00;
      word_count <= '0;
      len <= '0;
      acc <= '0;
      bidx <= '0;
      sh <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state <= LEN_HI;
          byte_ready <= 1'b1;
          cpu_hold <= 1'b1;
          done <= 1'b0;
          error <= 1'b0;
          err_code <= 2'b00;
          word_count <= '0;
          acc <= '0;
          bidx <= '0;
        end
        LEN_HI: if (hs) begin
          len[15:8] <= byte_in;
          state <= LEN_LO;
        end
        LEN_LO: if (hs) begin
          len <= n;
          if (n != 16'd0 && 32'(n) <= MAX_WORDS) state <= DATA;
          else begin
            state <= ERR;
            byte_ready <= 1'b0;
            error <= 1'b1;
            err_code <= 2'b01;
          end
        end
        DATA: if (hs) begin
          acc <= acc ^ byte_in;
          bidx <= bidx + 2'd1;
          sh <= {sh[15:0], byte_in};
          // the 4th byte completes a word; the write lands next cycle while ready stays up
          if (bidx == 2'd3) begin
            imem_we <= 1'b1;
            imem_wdata <= {sh, byte_in};
            imem_addr <= waddr;
            word_count <= word_count + 16'd1;
            if (word_count + 16'd1 == len) state <= CHK;
          end
        end
        CHK: if (hs) begin
          byte_ready <= 1'b0;
          if (byte_in == acc) begin
            state <= DONE;
            done <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state <= ERR;
            error <= 1'b1;
            err_code <= 2'b10;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic clk = 0, reset = 1, start = 0, byte_valid = 0;
  logic [7:0] byte_in = 0;
  logic byte_ready, imem_we, cpu_hold, done, error;
  logic [9:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [1:0] err_code;
  logic [15:0] word_count;
  int checks = 0, errors = 0, nw = 0;
  logic [9:0] wa [64];
  logic [31:0] wd [64];
  longint wt [64];
  logic [7:0] f1 [11] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
  logic [7:0] f2 [7] = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .err_code(err_code), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we && nw < 64) begin
    wa[nw] = imem_addr;
    wd[nw] = imem_wdata;
    wt[nw] = $time;
    nw++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    byte_in = b;
    byte_valid = 1;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      check("ready_timeout", 32'(t), 32'd0);
      byte_valid = 0;
    end else begin
      @(negedge clk);
      byte_valid = 0;
    end
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic frame1(input logic [7:0] chk, input int maxgap);
    for (int i = 0; i < 11; i++) send(i == 10 ? chk : f1[i], $urandom_range(0, maxgap));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_f1_writes(input string tag, input int base);
    check({tag, "_nw"}, 32'(nw - base), 32'd2);
    check({tag, "_a0"}, 32'(wa[base]), 32'h000);
    check({tag, "_d0"}, wd[base], 32'h12345678);
    check({tag, "_a1"}, 32'(wa[base+1]), 32'h004);
    check({tag, "_d1"}, wd[base+1], 32'h9ABCDEF0);
  endtask

  initial begin
    int b;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(byte_ready), 0);
    check("rst_we", 32'(imem_we), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_hold", 32'(cpu_hold), 1);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(error), 0);
    check("rst_wc", 32'(word_count), 0);
    reset = 0;
    @(negedge clk);
    check("idle_ready", 32'(byte_ready), 0);
    // 1: good two-word load, back-to-back bytes
    b = nw;
    pulse_start();
    check("t1_ready", 32'(byte_ready), 1);
    frame1(8'h00, 0);
    check_f1_writes("t1", b);
    check("t1_rate", 32'(wt[b+1] - wt[b]), 32'd40);
    check("t1_done", 32'(done), 1);
    check("t1_hold", 32'(cpu_hold), 0);
    check("t1_wc", 32'(word_count), 2);
    check("t1_err", 32'(error), 0);
    check("t1_ready_off", 32'(byte_ready), 0);
    // 2: checksum mismatch
    b = nw;
    pulse_start();
    check("t2_hold_start", 32'(cpu_hold), 1);
    frame1(8'hFF, 0);
    check_f1_writes("t2", b);
    check("t2_err", 32'(error), 1);
    check("t2_code", 32'(err_code), 2);
    check("t2_hold", 32'(cpu_hold), 1);
    check("t2_done", 32'(done), 0);
    // 3: bad lengths
    b = nw;
    pulse_start();
    check("t3_code_clr", 32'(err_code), 0);
    send(8'h01, 0);
    send(8'h01, 0);
    repeat (2) @(negedge clk);
    check("t3a_err", 32'(error), 1);
    check("t3a_code", 32'(err_code), 1);
    check("t3a_ready", 32'(byte_ready), 0);
    pulse_start();
    send(8'h00, 0);
    send(8'h00, 0);
    repeat (2) @(negedge clk);
    check("t3b_err", 32'(error), 1);
    check("t3b_code", 32'(err_code), 1);
    check("t3b_hold", 32'(cpu_hold), 1);
    check("t3_nowrite", 32'(nw - b), 0);
    // 4: random idle gaps
    b = nw;
    pulse_start();
    frame1(8'h00, 5);
    check_f1_writes("t4", b);
    check("t4_done", 32'(done), 1);
    check("t4_wc", 32'(word_count), 2);
    // 5: reset after six bytes
    b = nw;
    pulse_start();
    for (int i = 0; i < 6; i++) send(f1[i], 0);
    reset = 1;
    #1;
    check("t5_ready", 32'(byte_ready), 0);
    check("t5_we", 32'(imem_we), 0);
    check("t5_addr", 32'(imem_addr), 0);
    check("t5_wdata", imem_wdata, 0);
    check("t5_hold", 32'(cpu_hold), 1);
    check("t5_done", 32'(done), 0);
    check("t5_err", 32'(error), 0);
    check("t5_code", 32'(err_code), 0);
    check("t5_wc", 32'(word_count), 0);
    check("t5_partial", 32'(nw - b), 1);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    b = nw;
    pulse_start();
    frame1(8'h00, 0);
    check_f1_writes("t5r", b);
    check("t5r_done", 32'(done), 1);
    // 6: start ignored mid-load, then restart from DONE
    b = nw;
    pulse_start();
    for (int i = 0; i < 4; i++) send(f1[i], 0);
    pulse_start();
    for (int i = 4; i < 11; i++) send(f1[i], 0);
    repeat (2) @(negedge clk);
    check_f1_writes("t6", b);
    check("t6_done", 32'(done), 1);
    b = nw;
    pulse_start();
    check("t6_hold", 32'(cpu_hold), 1);
    check("t6_done_clr", 32'(done), 0);
    for (int i = 0; i < 7; i++) send(f2[i], 0);
    repeat (2) @(negedge clk);
    check("t6_nw", 32'(nw - b), 1);
    check("t6_a", 32'(wa[b]), 0);
    check("t6_d", wd[b], 32'hAABBCCDD);
    check("t6_wc", 32'(word_count), 1);
    check("t6_done2", 32'(done), 1);
    check("t6_hold2", 32'(cpu_hold), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
